// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: entry layout, field offsets,
// pop-count encodings and entry pack/unpack helpers.
package ifq_pkg;

  localparam int IFQ_PC_W   = 32;
  localparam int IFQ_INST_W = 32;
  localparam int ENTRY_W    = IFQ_PC_W + IFQ_INST_W + 1;

  localparam int INST_LSB  = 0;
  localparam int INST_MSB  = IFQ_INST_W - 1;
  localparam int PC_LSB    = IFQ_INST_W;
  localparam int PC_MSB    = IFQ_INST_W + IFQ_PC_W - 1;
  localparam int EXCEP_BIT = ENTRY_W - 1;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  typedef struct packed {
    logic                  excep;
    logic [IFQ_PC_W-1:0]   pc;
    logic [IFQ_INST_W-1:0] inst;
  } entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic                  excep,
                                                     input logic [IFQ_PC_W-1:0]   pc,
                                                     input logic [IFQ_INST_W-1:0] inst);
    return {excep, pc, inst};
  endfunction

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
    return entry_t'(raw);
  endfunction

  // The launch stage never retires more than two entries; encoding 3 folds onto two.
  function automatic pop_e clamp_pop(input logic [1:0] req);
    return (req == 2'd3) ? POP_TWO : pop_e'(req);
  endfunction

endpackage

// File: rtl/ifq_ram.sv
// Entry storage for the fetch queue: DEPTH x WIDTH register array with two write
// ports and two asynchronous read ports.
module ifq_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic [$clog2(DEPTH)-1:0] addr0,
  input  logic [WIDTH-1:0]         wdata0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] addr1,
  input  logic [WIDTH-1:0]         wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  output logic [WIDTH-1:0]         rdata0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output logic [WIDTH-1:0]         rdata1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity comes from the pointers, so clearing it only costs area.
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= wdata0;
    if (we1) mem[addr1] <= wdata1;
  end

  always_ff @(posedge clk) begin
    if (we0 && we1) assert (addr0 != addr1);
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-write, dual-read circular instruction queue between fetch and dual-issue launch.
// Optional IFQ_STAT_EN adds saturating full-stall and empty-cycle counters.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_line1_valid_i,
  input  logic                            in_line2_valid_i,
  input  logic [2*(PC_W+INST_W+1)-1:0]    in_bus_i,
  output logic                            in_allowin_o,
  output logic                            line1_valid_o,
  output logic                            line2_valid_o,
  output logic [2*(PC_W+INST_W+1)-1:0]    out_bus_o,
  input  logic [1:0]                      pop_num_i,
  input  logic                            flush_i,
  output logic [$clog2(DEPTH):0]          count_o
`ifdef IFQ_STAT_EN
  ,
  output logic [31:0]                     full_stall_cnt_o,
  output logic [31:0]                     empty_cnt_o
`endif
);

  localparam int LINE_W = PC_W + INST_W + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [LINE_W-1:0] in_e1, in_e2, rd_e1, rd_e2, wdata0;
  logic              push_ok, we1;
  logic [1:0]        pop_req_raw;
  logic [CNT_W-1:0]  push_n, pop_req, pop_n;

  assign in_e1 = in_bus_i[LINE_W-1:0];
  assign in_e2 = in_bus_i[2*LINE_W-1:LINE_W];

  // Admission looks only at registered occupancy; slots freed by this cycle's pop wait a cycle.
  assign in_allowin_o = (count <= CNT_W'(DEPTH - 2));
  assign push_ok      = in_allowin_o & (in_line1_valid_i | in_line2_valid_i);
  assign we1          = push_ok & in_line1_valid_i & in_line2_valid_i;
  assign wdata0       = in_line1_valid_i ? in_e1 : in_e2;
  assign pop_req_raw  = clamp_pop(pop_num_i);
  assign pop_req      = CNT_W'(pop_req_raw);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    push_n = '0;
    if (push_ok) push_n = CNT_W'(in_line1_valid_i) + CNT_W'(in_line2_valid_i);
    pop_n = (pop_req > count) ? count : pop_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_n[PTR_W-1:0];
      tail  <= tail + push_n[PTR_W-1:0];
      count <= count + push_n - pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) assert (pop_req <= count);
  end

  ifq_ram #(.DEPTH(DEPTH), .WIDTH(LINE_W)) u_ram (
    .clk    (clk),
    .we0    (push_ok),
    .addr0  (tail),
    .wdata0 (wdata0),
    .we1    (we1),
    .addr1  (tail + PTR_W'(1)),
    .wdata1 (in_e2),
    .raddr0 (head),
    .rdata0 (rd_e1),
    .raddr1 (head + PTR_W'(1)),
    .rdata1 (rd_e2)
  );

  assign out_bus_o     = {rd_e2, rd_e1};
  assign line1_valid_o = (count != '0);
  assign line2_valid_o = (count >= CNT_W'(2));
  assign count_o       = count;

`ifdef IFQ_STAT_EN
  // Statistics survive flushes; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_stall_cnt_o <= '0;
      empty_cnt_o      <= '0;
    end else begin
      if (!in_allowin_o && (in_line1_valid_i || in_line2_valid_i) && full_stall_cnt_o != '1)
        full_stall_cnt_o <= full_stall_cnt_o + 32'd1;
      if (count == '0 && empty_cnt_o != '1)
        empty_cnt_o <= empty_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=8, 32-bit PC/inst).
module tb_inst_fetch_queue;
  import ifq_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_line1_valid_i, in_line2_valid_i;
  logic [2*ENTRY_W-1:0] in_bus_i;
  logic                 in_allowin_o, line1_valid_o, line2_valid_o;
  logic [2*ENTRY_W-1:0] out_bus_o;
  logic [1:0]           pop_num_i;
  logic                 flush_i;
  logic [3:0]           count_o;
`ifdef IFQ_STAT_EN
  logic [31:0]          full_stall_cnt_o, empty_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  inst_fetch_queue #(.DEPTH(8), .PC_W(32), .INST_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_line1_valid_i (in_line1_valid_i),
    .in_line2_valid_i (in_line2_valid_i),
    .in_bus_i         (in_bus_i),
    .in_allowin_o     (in_allowin_o),
    .line1_valid_o    (line1_valid_o),
    .line2_valid_o    (line2_valid_o),
    .out_bus_o        (out_bus_o),
    .pop_num_i        (pop_num_i),
    .flush_i          (flush_i),
    .count_o          (count_o)
`ifdef IFQ_STAT_EN
    ,
    .full_stall_cnt_o (full_stall_cnt_o),
    .empty_cnt_o      (empty_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v1, input logic v2, input logic [31:0] pc1,
                       input logic [31:0] pc2, input logic x2, input logic [1:0] pop,
                       input logic fl);
    in_line1_valid_i = v1;
    in_line2_valid_i = v2;
    in_bus_i  = {pack_entry(x2, pc2, pc2 ^ 32'h13), pack_entry(1'b0, pc1, pc1 ^ 32'h13)};
    pop_num_i = pop;
    flush_i   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] l1_pc();
    entry_t e;
    e = unpack_entry(out_bus_o[ENTRY_W-1:0]);
    return e.pc;
  endfunction

  function automatic logic [31:0] l2_pc();
    entry_t e;
    e = unpack_entry(out_bus_o[2*ENTRY_W-1:ENTRY_W]);
    return e.pc;
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("rst_count",   64'(count_o), 64'd0);
    check("rst_l1v",     64'(line1_valid_o), 64'd0);
    check("rst_l2v",     64'(line2_valid_o), 64'd0);
    check("rst_allowin", 64'(in_allowin_o), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Basic pair, no bypass before the edge
    drive(1, 1, 32'h1C000000, 32'h1C000004, 0, 0, 0);
    #1;
    check("no_bypass_l1v", 64'(line1_valid_o), 64'd0);
    tick();
    check("pair_l1pc",  64'(l1_pc()), 64'h1C000000);
    check("pair_l1inst", 64'(out_bus_o[INST_MSB:INST_LSB]), 64'h1C000013);
    check("pair_l2pc",  64'(l2_pc()), 64'h1C000004);
    check("pair_count", 64'(count_o), 64'd2);
    check("pair_l2v",   64'(line2_valid_o), 64'd1);

    // Single issue: line2 moves up to line1
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    check("single_l1pc",  64'(l1_pc()), 64'h1C000004);
    check("single_l2v",   64'(line2_valid_o), 64'd0);
    check("single_count", 64'(count_o), 64'd1);

    // Only line2 valid is compacted to tail, exception bit carried
    drive(0, 1, 32'hFFFF_FFFF, 32'h1C000008, 1, 0, 0);
    tick();
    check("compact_count", 64'(count_o), 64'd2);
    check("compact_l2pc",  64'(l2_pc()), 64'h1C000008);
    check("compact_excep", 64'(out_bus_o[ENTRY_W+EXCEP_BIT]), 64'd1);

    // Pop encoding 3 retires two
    drive(0, 0, 0, 0, 0, 3, 0);
    tick();
    check("pop3_count", 64'(count_o), 64'd0);
    check("pop3_l1v",   64'(line1_valid_o), 64'd0);

    // Fill: four pairs, head=tail=3 at start
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 32'h200 + 32'(8*k), 32'h204 + 32'(8*k), 0, 0, 0);
      check($sformatf("fill_allowin_%0d", k), 64'(in_allowin_o), 64'd1);
      tick();
    end
    check("full_count",   64'(count_o), 64'd8);
    check("full_allowin", 64'(in_allowin_o), 64'd0);

    drive(1, 1, 32'h900, 32'h904, 0, 0, 0);
    tick();
    check("full_ignore_count", 64'(count_o), 64'd8);
    check("full_ignore_l1pc",  64'(l1_pc()), 64'h200);

    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    check("c7_count",   64'(count_o), 64'd7);
    check("c7_allowin", 64'(in_allowin_o), 64'd0);
    check("c7_l1pc",    64'(l1_pc()), 64'h204);

    // Same-cycle pop does not open the door for the offered pair
    drive(1, 1, 32'h900, 32'h904, 0, 2, 0);
    tick();
    check("nofree_count", 64'(count_o), 64'd5);
    check("nofree_l1pc",  64'(l1_pc()), 64'h20C);
    check("nofree_allowin", 64'(in_allowin_o), 64'd1);

    drive(1, 0, 32'h300, 0, 0, 0, 0);
    tick();
    check("pre_flush_count", 64'(count_o), 64'd6);

    // Flush with concurrent push and pop
    drive(1, 1, 32'h910, 32'h914, 0, 2, 1);
    #1;
    check("flush_allowin_same", 64'(in_allowin_o), 64'd1);
    tick();
    check("flush_count",   64'(count_o), 64'd0);
    check("flush_l1v",     64'(line1_valid_o), 64'd0);
    check("flush_l2v",     64'(line2_valid_o), 64'd0);
    check("flush_allowin", 64'(in_allowin_o), 64'd1);

    // Walk head to index 7 with count 2
    drive(1, 0, 32'h400, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(1, 1, 32'h410, 32'h414, 0, 0, 0);
    tick();
    drive(1, 1, 32'h418, 32'h41C, 0, 2, 0);
    tick();
    drive(1, 1, 32'h420, 32'h424, 0, 2, 0);
    tick();
    drive(1, 1, 32'h428, 32'h42C, 0, 2, 0);
    tick();
    check("straddle_l1pc", 64'(l1_pc()), 64'h428);
    check("straddle_l2pc", 64'(l2_pc()), 64'h42C);
    check("straddle_count", 64'(count_o), 64'd2);

    drive(1, 1, 32'h430, 32'h434, 0, 2, 0);
    tick();
    check("wrap_l1pc",  64'(l1_pc()), 64'h430);
    check("wrap_l2pc",  64'(l2_pc()), 64'h434);
    check("wrap_count", 64'(count_o), 64'd2);

    // Asynchronous reset mid-traffic
    drive(1, 1, 32'h440, 32'h444, 0, 0, 0);
    tick();
    drive(1, 0, 32'h448, 0, 0, 0, 0);
    tick();
    check("pre_rst_count", 64'(count_o), 64'd5);
    drive(1, 1, 32'h450, 32'h454, 0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count",   64'(count_o), 64'd0);
    check("async_rst_l1v",     64'(line1_valid_o), 64'd0);
    check("async_rst_l2v",     64'(line2_valid_o), 64'd0);
    check("async_rst_allowin", 64'(in_allowin_o), 64'd1);
    tick();
    check("held_rst_count", 64'(count_o), 64'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("post_rst_l1v", 64'(line1_valid_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
